// File: rtl/lsu_mmio_if.sv
// Core-side bus bundle for the memory-mapped load/store unit.
// Request fields flow master->slave; load result and error flow back.
interface lsu_mmio_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       st_data_i;
    logic              st_en_i;
    logic              ld_en_i;
    logic [1:0]        size_i;
    logic              ld_unsigned_i;
    logic [31:0]       ld_data_o;
    logic              ld_valid_o;
    logic              err_o;

    modport master (
        output addr_i, st_data_i, st_en_i, ld_en_i, size_i, ld_unsigned_i,
        input  ld_data_o, ld_valid_o, err_o
    );

    modport slave (
        input  addr_i, st_data_i, st_en_i, ld_en_i, size_i, ld_unsigned_i,
        output ld_data_o, ld_valid_o, err_o
    );
endinterface

// File: rtl/lsu_mmio.sv
// Memory-mapped load/store unit: data RAM, output peripheral registers
// and a synchronised switch port, byte/half/word with error reporting.
module lsu_mmio #(
    parameter int ADDR_W  = 12,
    parameter int DMEM_AW = 9,
    parameter int NUM_HEX = 8,
    parameter int SW_W    = 18
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    lsu_mmio_if.slave            bus,
    input  logic [SW_W-1:0]      io_sw_i,
    output logic [NUM_HEX*32-1:0] io_hex_o,
    output logic [31:0]          io_ledr_o,
    output logic [31:0]          io_ledg_o,
    output logic [31:0]          io_lcd_o
);
    localparam int HW = (NUM_HEX > 1) ? $clog2(NUM_HEX) : 1;

    logic [31:0]        mem_q [2**DMEM_AW];
    logic [31:0]        hex_q [NUM_HEX];
    logic [31:0]        ledr_q, ledg_q, lcd_q;
    logic [SW_W-1:0]    sw_meta_q, sw_sync_q;
    logic [31:0]        ld_data_q;
    logic               ld_valid_q, err_q;

    logic [31:0]        a32, wa32;
    logic               is_mem, is_hex, is_ledr, is_ledg, is_lcd, is_sw;
    logic               misal, fault, st_ok, ld_ok, err_d;
    logic [3:0]         lane_m;
    logic [31:0]        bit_m, wdata, rword, rsh, ld_ext, ld_data_d;
    logic [HW-1:0]      hex_idx;
    logic [DMEM_AW-1:0] mem_idx;

    // Address decode, alignment check and fault classification.
    always_comb begin
        a32     = 32'(bus.addr_i);
        wa32    = a32 >> 2;
        is_mem  = (a32 >> (DMEM_AW + 2)) == 32'd0;
        is_hex  = (wa32 >= 32'h200) && (wa32 < 32'h200 + NUM_HEX);
        is_ledr = wa32 == 32'h220;
        is_ledg = wa32 == 32'h224;
        is_lcd  = wa32 == 32'h228;
        is_sw   = wa32 == 32'h240;
        hex_idx = wa32[HW-1:0];
        mem_idx = wa32[DMEM_AW-1:0];
        misal   = (bus.size_i == 2'b01 && a32[0]) ||
                  (bus.size_i == 2'b10 && a32[1:0] != 2'b00);
        fault   = (bus.size_i == 2'b11) || misal ||
                  !(is_mem || is_hex || is_ledr || is_ledg || is_lcd || is_sw) ||
                  (bus.st_en_i && is_sw);
        st_ok   = bus.st_en_i && !fault;
        ld_ok   = bus.ld_en_i && !bus.st_en_i && !fault;
        err_d   = (bus.st_en_i || bus.ld_en_i) &&
                  (fault || (bus.st_en_i && bus.ld_en_i));
    end

    // Byte-lane mask and replicated store data.
    always_comb begin
        lane_m = 4'b0000;
        wdata  = 32'd0;
        case (bus.size_i)
            2'b00: begin
                lane_m = 4'b0001 << a32[1:0];
                wdata  = {4{bus.st_data_i[7:0]}};
            end
            2'b01: begin
                lane_m = 4'b0011 << a32[1:0];
                wdata  = {2{bus.st_data_i[15:0]}};
            end
            2'b10: begin
                lane_m = 4'b1111;
                wdata  = bus.st_data_i;
            end
            default: ;
        endcase
        bit_m = {{8{lane_m[3]}}, {8{lane_m[2]}}, {8{lane_m[1]}}, {8{lane_m[0]}}};
    end

    // Read mux, lane extraction and sign/zero extension.
    always_comb begin
        rword = 32'd0;
        if (is_mem)       rword = mem_q[mem_idx];
        else if (is_hex)  rword = hex_q[hex_idx];
        else if (is_ledr) rword = ledr_q;
        else if (is_ledg) rword = ledg_q;
        else if (is_lcd)  rword = lcd_q;
        else if (is_sw)   rword = 32'(sw_sync_q);
        rsh = rword >> {a32[1:0], 3'b000};
        case (bus.size_i)
            2'b00:   ld_ext = bus.ld_unsigned_i ? {24'd0, rsh[7:0]}
                                                : {{24{rsh[7]}}, rsh[7:0]};
            2'b01:   ld_ext = bus.ld_unsigned_i ? {16'd0, rsh[15:0]}
                                                : {{16{rsh[15]}}, rsh[15:0]};
            default: ld_ext = rword;
        endcase
        ld_data_d = ld_ok ? ld_ext : 32'd0;
    end

    // Data memory: byte-lane writes, contents survive reset.
    always_ff @(posedge clk_i) begin
        if (st_ok && is_mem) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_m[b]) mem_q[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Peripheral registers, switch synchroniser and load/error outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_HEX; k++) hex_q[k] <= 32'd0;
            ledr_q     <= 32'd0;
            ledg_q     <= 32'd0;
            lcd_q      <= 32'd0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            ld_data_q  <= 32'd0;
            ld_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_HEX; k++) begin
                if (st_ok && is_hex && hex_idx == HW'(k))
                    hex_q[k] <= (hex_q[k] & ~bit_m) | (wdata & bit_m);
            end
            if (st_ok && is_ledr) ledr_q <= (ledr_q & ~bit_m) | (wdata & bit_m);
            if (st_ok && is_ledg) ledg_q <= (ledg_q & ~bit_m) | (wdata & bit_m);
            if (st_ok && is_lcd)  lcd_q  <= (lcd_q & ~bit_m) | (wdata & bit_m);
            sw_meta_q  <= io_sw_i;
            sw_sync_q  <= sw_meta_q;
            if (bus.ld_en_i) ld_data_q <= ld_data_d;
            ld_valid_q <= bus.ld_en_i;
            err_q      <= err_d;
        end
    end

    // Output wiring.
    always_comb begin
        for (int k = 0; k < NUM_HEX; k++) io_hex_o[32*k +: 32] = hex_q[k];
        io_ledr_o      = ledr_q;
        io_ledg_o      = ledg_q;
        io_lcd_o       = lcd_q;
        bus.ld_data_o  = ld_data_q;
        bus.ld_valid_o = ld_valid_q;
        bus.err_o      = err_q;
    end
endmodule

// File: tb/tb_lsu_mmio.sv
// Directed self-checking bench for lsu_mmio.
// Each task drives one scenario and compares against hand-computed values.
module tb_lsu_mmio;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [17:0]   sw  = 18'd0;
    logic [255:0]  hex;
    logic [31:0]   ledr, ledg, lcd;
    int            n_cmp = 0;
    int            n_bad = 0;

    lsu_mmio_if #(.ADDR_W(12)) bus ();

    lsu_mmio #(.ADDR_W(12), .DMEM_AW(9), .NUM_HEX(8), .SW_W(18)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .io_sw_i   (sw),
        .io_hex_o  (hex),
        .io_ledr_o (ledr),
        .io_ledg_o (ledg),
        .io_lcd_o  (lcd)
    );

    always #5 clk = ~clk;

    // One request cycle: set at negedge, sample 1 time unit after the edge.
    task automatic req(input logic st, input logic ld, input logic [11:0] a,
                       input logic [31:0] d, input logic [1:0] sz,
                       input logic uns);
        @(negedge clk);
        bus.st_en_i = st; bus.ld_en_i = ld; bus.addr_i = a;
        bus.st_data_i = d; bus.size_i = sz; bus.ld_unsigned_i = uns;
        @(posedge clk); #1;
        bus.st_en_i = 1'b0; bus.ld_en_i = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.st_en_i = 1'b0; bus.ld_en_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic chk_ld(input string nm, input logic [31:0] exp_d,
                          input logic exp_e);
        n_cmp++;
        if (bus.ld_valid_o !== 1'b1 || bus.ld_data_o !== exp_d ||
            bus.err_o !== exp_e) begin
            n_bad++;
            $display("FAIL %s: got v=%b d=%h e=%b, want v=1 d=%h e=%b", nm,
                     bus.ld_valid_o, bus.ld_data_o, bus.err_o, exp_d, exp_e);
        end
    endtask

    task automatic test_reset();
        bus.st_en_i = 0; bus.ld_en_i = 0; bus.addr_i = 0;
        bus.st_data_i = 0; bus.size_i = 0; bus.ld_unsigned_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        idle();
        n_cmp++;
        if (hex !== 256'd0 || ledr !== 0 || ledg !== 0 || lcd !== 0 ||
            bus.ld_valid_o !== 0 || bus.err_o !== 0 || bus.ld_data_o !== 0) begin
            n_bad++;
            $display("FAIL reset_idle: got v=%b e=%b d=%h ledr=%h, want all 0",
                     bus.ld_valid_o, bus.err_o, bus.ld_data_o, ledr);
        end
        req(1'b0, 1'b1, 12'h900, 0, 2'b10, 1'b0);
        chk_ld("reset_preload", 32'd0, 1'b0);
        req(1'b0, 1'b1, 12'h010, 0, 2'b10, 1'b0);
        rst = 1'b1; #1;
        n_cmp++;
        if (bus.ld_valid_o !== 1'b0 || bus.ld_data_o !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_async: got v=%b d=%h, want v=0 d=0",
                     bus.ld_valid_o, bus.ld_data_o);
        end
        @(negedge clk); rst = 1'b0;
        idle();
        n_cmp++;
        if (bus.ld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_midload: got v=%b, want 0", bus.ld_valid_o);
        end
    endtask

    task automatic test_mem();
        req(1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 2'b10, 1'b0);
        n_cmp++;
        if (bus.err_o !== 1'b0 || bus.ld_valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mem_store: got e=%b v=%b, want 0 0",
                     bus.err_o, bus.ld_valid_o);
        end
        req(1'b0, 1'b1, 12'h013, 0, 2'b00, 1'b0);
        chk_ld("mem_lb_s", 32'hFFFFFFDE, 1'b0);
        req(1'b0, 1'b1, 12'h013, 0, 2'b00, 1'b1);
        chk_ld("mem_lb_u", 32'h000000DE, 1'b0);
        req(1'b0, 1'b1, 12'h010, 0, 2'b01, 1'b0);
        chk_ld("mem_lh_s", 32'hFFFFBEEF, 1'b0);
        idle();
        n_cmp++;
        if (bus.ld_valid_o !== 1'b0 || bus.ld_data_o !== 32'hFFFFBEEF) begin
            n_bad++;
            $display("FAIL mem_hold: got v=%b d=%h, want v=0 d=ffffbeef",
                     bus.ld_valid_o, bus.ld_data_o);
        end
        req(1'b0, 1'b1, 12'h012, 0, 2'b01, 1'b1);
        chk_ld("mem_lh_u", 32'h0000DEAD, 1'b0);
        req(1'b0, 1'b1, 12'h011, 0, 2'b00, 1'b0);
        chk_ld("mem_lb_lane1", 32'hFFFFFFBE, 1'b0);
        req(1'b1, 1'b0, 12'h7FC, 32'hA5A50F0F, 2'b10, 1'b0);
        req(1'b0, 1'b1, 12'h7FC, 0, 2'b10, 1'b0);
        chk_ld("mem_top_word", 32'hA5A50F0F, 1'b0);
    endtask

    task automatic test_periph();
        req(1'b1, 1'b0, 12'h808, 32'h11223344, 2'b10, 1'b0);
        req(1'b1, 1'b0, 12'h880, 32'h00000F0F, 2'b10, 1'b0);
        n_cmp++;
        if (hex[95:64] !== 32'h11223344 || ledr !== 32'h00000F0F ||
            hex[63:0] !== 64'd0) begin
            n_bad++;
            $display("FAIL periph_hold: got hex2=%h ledr=%h, want 11223344 00000f0f",
                     hex[95:64], ledr);
        end
        req(1'b1, 1'b0, 12'h809, 32'h000000AA, 2'b00, 1'b0);
        n_cmp++;
        if (hex[95:64] !== 32'h1122AA44 || ledr !== 32'h00000F0F) begin
            n_bad++;
            $display("FAIL periph_merge: got hex2=%h ledr=%h, want 1122aa44 00000f0f",
                     hex[95:64], ledr);
        end
        req(1'b1, 1'b0, 12'h892, 32'h0000BEEF, 2'b01, 1'b0);
        req(1'b1, 1'b0, 12'h8A0, 32'hCAFE0001, 2'b10, 1'b0);
        n_cmp++;
        if (ledg !== 32'hBEEF0000 || lcd !== 32'hCAFE0001) begin
            n_bad++;
            $display("FAIL periph_ledg_lcd: got ledg=%h lcd=%h, want beef0000 cafe0001",
                     ledg, lcd);
        end
        req(1'b0, 1'b1, 12'h808, 0, 2'b10, 1'b0);
        chk_ld("periph_read", 32'h1122AA44, 1'b0);
        req(1'b1, 1'b0, 12'h81C, 32'h77777777, 2'b10, 1'b0);
        n_cmp++;
        if (hex[255:224] !== 32'h77777777) begin
            n_bad++;
            $display("FAIL periph_hex7: got %h, want 77777777", hex[255:224]);
        end
    endtask

    task automatic test_switch();
        @(negedge clk); sw = 18'h2A5A5;
        idle(); idle();
        req(1'b0, 1'b1, 12'h900, 0, 2'b10, 1'b0);
        chk_ld("sw_read", 32'h0002A5A5, 1'b0);
        req(1'b0, 1'b1, 12'h900, 0, 2'b00, 1'b1);
        chk_ld("sw_byte", 32'h000000A5, 1'b0);
        req(1'b1, 1'b0, 12'h900, 32'hFFFFFFFF, 2'b10, 1'b0);
        n_cmp++;
        if (bus.err_o !== 1'b1 || ledr !== 32'h00000F0F ||
            hex[95:64] !== 32'h1122AA44 || lcd !== 32'hCAFE0001) begin
            n_bad++;
            $display("FAIL sw_store: got e=%b ledr=%h, want e=1 ledr=00000f0f",
                     bus.err_o, ledr);
        end
    endtask

    task automatic test_errors();
        req(1'b0, 1'b1, 12'h012, 0, 2'b10, 1'b0);
        chk_ld("err_word_misal", 32'd0, 1'b1);
        idle();
        n_cmp++;
        if (bus.err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse: got e=%b, want 0", bus.err_o);
        end
        req(1'b1, 1'b0, 12'h011, 32'h00001111, 2'b01, 1'b0);
        n_cmp++;
        if (bus.err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sh_misal: got e=%b, want 1", bus.err_o);
        end
        req(1'b0, 1'b1, 12'h010, 0, 2'b10, 1'b0);
        chk_ld("err_mem_kept", 32'hDEADBEEF, 1'b0);
        req(1'b0, 1'b1, 12'hA00, 0, 2'b10, 1'b0);
        chk_ld("err_unmapped", 32'd0, 1'b1);
        req(1'b0, 1'b1, 12'h820, 0, 2'b10, 1'b0);
        chk_ld("err_hex_oob", 32'd0, 1'b1);
        req(1'b0, 1'b1, 12'h010, 0, 2'b11, 1'b0);
        chk_ld("err_size11", 32'd0, 1'b1);
        req(1'b1, 1'b0, 12'h884, 32'h12345678, 2'b10, 1'b0);
        n_cmp++;
        if (bus.err_o !== 1'b1 || ledr !== 32'h00000F0F) begin
            n_bad++;
            $display("FAIL err_st_unmapped: got e=%b ledr=%h, want 1 00000f0f",
                     bus.err_o, ledr);
        end
    endtask

    task automatic test_hazard();
        req(1'b1, 1'b0, 12'h020, 32'h12345678, 2'b10, 1'b0);
        req(1'b0, 1'b1, 12'h020, 0, 2'b10, 1'b0);
        chk_ld("haz_raw", 32'h12345678, 1'b0);
        req(1'b1, 1'b1, 12'h024, 32'h55667788, 2'b10, 1'b0);
        chk_ld("haz_st_ld", 32'd0, 1'b1);
        req(1'b0, 1'b1, 12'h024, 0, 2'b10, 1'b0);
        chk_ld("haz_st_landed", 32'h55667788, 1'b0);
        req(1'b0, 1'b1, 12'h010, 0, 2'b10, 1'b0);
        chk_ld("b2b_first", 32'hDEADBEEF, 1'b0);
        req(1'b0, 1'b1, 12'h022, 0, 2'b01, 1'b1);
        chk_ld("b2b_second", 32'h00001234, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mem();
        test_periph();
        test_switch();
        test_errors();
        test_hazard();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_mmio.md
Name: lsu_mmio

Overview:
- Parametrised memory-mapped load/store unit for the single-cycle/pipelined core.
- Contains a word-organised data memory, a bank of persistent output peripheral registers (NUM_HEX hex digits, red LEDs, green LEDs, LCD) and a synchronised switch input port.
- Supports byte, halfword and word accesses with sign/zero extension, registered load data with a valid strobe, and misalignment/unmapped-access error reporting.

Parameters:
ADDR_W, 12, byte address width
DMEM_AW, 9, data memory word-address width (2^DMEM_AW words of 32 bit)
NUM_HEX, 8, number of hex display registers (1..16)
SW_W, 18, switch input width (1..32)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
addr_i  in  ADDR_W  byte address
st_data_i  in  32  store data, right-aligned
st_en_i  in  1  store request
ld_en_i  in  1  load request
size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
ld_unsigned_i  in  1  1 = zero-extend load, 0 = sign-extend load
io_sw_i  in  SW_W  asynchronous switch inputs
ld_data_o  out  32  load result
ld_valid_o  out  1  load result valid strobe
err_o  out  1  access error strobe
io_hex_o  out  NUM_HEX*32  hex registers; hex k occupies bits [32k+31:32k]
io_ledr_o  out  32  red LED register
io_ledg_o  out  32  green LED register
io_lcd_o  out  32  LCD register

Behaviour:
- Memory map by byte address:
  - Data memory: 0 .. 4*2^DMEM_AW-1.
  - hex k: 0x800+4k.
  - ledr: 0x880. ledg: 0x890. lcd: 0x8A0.
  - Switches: 0x900, read-only.
  - Anything else is unmapped. Data memory must not overlap 0x800; this is a parameter legality rule, not checked at run time.
- Reset (rst_i high, asynchronous):
  - ld_data_o, ld_valid_o, err_o and all io_* registers go to 0 immediately.
  - Switch synchroniser goes to 0.
  - Data memory contents are not reset.
  - A load in flight is discarded; no ld_valid_o follows reset release.
- Alignment:
  - Half requires addr_i[0]=0; word requires addr_i[1:0]=00.
  - Misaligned access, size_i=11, a store to the switch address, or an unmapped access of any kind pulses err_o for one cycle, on the cycle after the request.
  - A faulted store writes nothing.
  - A faulted load returns ld_data_o=0 and still pulses ld_valid_o, so the core never stalls.
- Stores:
  - Committed at the rising edge of the request cycle.
  - Byte lane mask = size shifted by addr_i[1:0]; st_data_i is replicated into the active lanes.
  - Peripheral registers update only the active lanes; other bytes are held.
- Loads:
  - Latency 1: ld_valid_o is high for exactly the cycle after an accepted ld_en_i.
  - The selected lane(s) are extracted and then sign/zero-extended to 32 bits.
  - ld_data_o holds its value until the next load completes.
  - Back-to-back loads give one result per cycle.
- Switch reads: a 2-flop synchroniser, zero-extended to 32 bits. A load returns the switch value sampled at least 2 edges earlier.
- Peripheral reads return the current register value.
- Simultaneous st_en_i and ld_en_i:
  - The store executes.
  - The load is rejected: err_o pulses, and ld_valid_o pulses with 0 data.
- Store followed by a load of the same address in the next cycle returns the newly stored data (write-first ordering).
- Outputs are registered and persistent. A peripheral holds its value until it is rewritten or reset; it is not cleared by accesses to other addresses.

Test Plan:
- Reset then idle -> all io_* = 0, ld_valid_o = 0, err_o = 0. Assert rst_i mid-load -> no ld_valid_o after reset release.
- Data memory word and byte access:
  - Store word 0xDEADBEEF @0x010.
  - Load byte signed @0x013 -> 0xFFFFFFDE.
  - Load byte unsigned @0x013 -> 0x000000DE.
  - Load half @0x010 signed -> 0xFFFFBEEF.
  - Each result has ld_valid_o high 1 cycle after the request.
- Peripheral persistence and lane merge:
  - Store word 0x11223344 @0x808 -> hex2 = 0x11223344, held across later accesses to 0x880.
  - Then store byte 0xAA @0x809 -> hex2 = 0x1122AA44.
- Switch path:
  - Set io_sw_i = 0x2A5A5 -> load @0x900 two or more cycles later returns 0x0002A5A5.
  - Store @0x900 -> err_o pulse, no register changes.
- Errors:
  - Word load @0x012 -> err_o = 1, ld_data_o = 0.
  - Store half @0x011 -> err_o, memory unchanged.
  - Load @0xA00 -> err_o, data 0.
  - size_i = 11 -> err_o.
- Hazards:
  - Store 0x12345678 @0x020 then load @0x020 next cycle -> 0x12345678.
  - st_en_i and ld_en_i together -> store lands, err_o pulses, load data 0.
